// File: rtl/btb_pkg.sv
// btb_pkg: shared definitions for the BTB update controller.
//   BTB_IDX_W / BTB_TAG_W : BTB geometry (idx = pc[9:2], tag = pc[13:10])
//   RES_FIFO_DEPTH        : resolution buffer depth
//   btb_state_e           : controller states
//   btb_res_t             : buffered branch resolution (pc, target, taken)
//   ctr_next()            : 2-bit saturating counter update
package btb_pkg;

    localparam int BTB_IDX_W      = 8;
    localparam int BTB_TAG_W      = 4;
    localparam int RES_FIFO_DEPTH = 4;
    localparam int RES_CNT_W      = $clog2(RES_FIFO_DEPTH + 1);
    localparam int RES_PTR_W      = $clog2(RES_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_INVAL  = 2'd2
    } btb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } btb_res_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        if (taken) return (cur == 2'd3) ? 2'd3 : cur + 2'd1;
        else       return (cur == 2'd0) ? 2'd0 : cur - 2'd1;
    endfunction

endpackage

// File: rtl/btb_res_fifo.sv
// btb_res_fifo: resolution buffer, RES_FIFO_DEPTH entries, show-ahead head.
//   clk_i, rst_ni : clock, async active-low reset (empties the buffer)
//   push_i, din_i : write request/data (ignored when full, even with a pop)
//   pop_i         : drop head (ignored when empty)
//   dout_o        : head entry
//   empty_o/full_o/count_o : occupancy
import btb_pkg::*;

module btb_res_fifo (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  btb_res_t             din_i,
    input  logic                 pop_i,
    output btb_res_t             dout_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [RES_CNT_W-1:0] count_o
);

    localparam logic [RES_CNT_W-1:0] FULL_CNT = RES_CNT_W'(RES_FIFO_DEPTH);

    btb_res_t             mem [RES_FIFO_DEPTH];
    logic [RES_PTR_W-1:0] wr_ptr, rd_ptr;
    logic [RES_CNT_W-1:0] cnt_q;
    logic                 do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign dout_o  = mem[rd_ptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: buffers EX-stage branch resolutions and writes them into
// the BTB one per cycle, runs a full-table invalidation sweep on request, and
// flags mispredictions with the corrected fetch PC.
//   clk_i, rst_ni            : clock, async active-low reset
//   res_*_i / res_ready_o    : resolution handshake (accepted on valid && ready)
//   inv_req_i / inv_busy_o   : invalidation sweep request / in progress
//   btb_*_o, btb_ctr_rd_i    : BTB write port plus same-cycle counter read
//   mispredict_o, redirect_pc_o : one-cycle mispredict pulse and correct PC
// Optional: define BTB_UPD_STATS_EN to add stat_upd_o / stat_mis_o counters.
import btb_pkg::*;

module btb_update_ctrl (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 res_valid_i,
    input  logic [31:0]          res_pc_i,
    input  logic [31:0]          res_target_i,
    input  logic                 res_taken_i,
    input  logic                 res_pred_taken_i,
    output logic                 res_ready_o,
    input  logic                 inv_req_i,
    output logic                 inv_busy_o,
    output logic                 btb_we_o,
    output logic [BTB_IDX_W-1:0] btb_idx_o,
    output logic [BTB_TAG_W-1:0] btb_tag_o,
    output logic [31:0]          btb_target_o,
    output logic                 btb_valid_o,
    output logic [1:0]           btb_ctr_o,
    input  logic [1:0]           btb_ctr_rd_i,
    output logic                 mispredict_o,
    output logic [31:0]          redirect_pc_o
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [15:0]          stat_upd_o,
    output logic [15:0]          stat_mis_o
`endif
);

    btb_state_e           state_q, state_d;
    logic [BTB_IDX_W-1:0] sweep_q;
    logic                 push, pop, fifo_empty, fifo_full;
    logic [RES_CNT_W-1:0] fifo_cnt;
    btb_res_t             res_in, head;
    logic                 mis_q;
    logic [31:0]          redir_q;
    logic                 unused_pc_bits;

    assign res_ready_o = !fifo_full;
    assign push        = res_valid_i && res_ready_o;
    assign pop         = (state_q == ST_UPDATE) && !fifo_empty;
    assign res_in      = '{pc: res_pc_i, target: res_target_i, taken: res_taken_i};

    // Only the idx and tag fields of the buffered PC reach the BTB.
    assign unused_pc_bits = ^{head.pc[31:2+BTB_IDX_W+BTB_TAG_W], head.pc[1:0]};

    btb_res_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (res_in),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    // State register and sweep index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            // Wraps to 0 after index 255, ready for the next sweep.
            if (state_q == ST_INVAL) sweep_q <= sweep_q + 1'b1;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_req_i)        state_d = ST_INVAL;
                else if (!fifo_empty) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // The write for this cycle still completes before the sweep.
                if (inv_req_i)                                          state_d = ST_INVAL;
                else if (fifo_cnt <= RES_CNT_W'(1) && !push)            state_d = ST_IDLE;
            end
            ST_INVAL: begin
                if (sweep_q == '1) state_d = fifo_empty ? ST_IDLE : ST_UPDATE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        btb_we_o     = 1'b0;
        btb_idx_o    = '0;
        btb_tag_o    = '0;
        btb_target_o = '0;
        btb_valid_o  = 1'b0;
        btb_ctr_o    = '0;
        case (state_q)
            ST_UPDATE: begin
                if (!fifo_empty) begin
                    btb_we_o     = 1'b1;
                    btb_idx_o    = head.pc[2 +: BTB_IDX_W];
                    btb_tag_o    = head.pc[2+BTB_IDX_W +: BTB_TAG_W];
                    btb_target_o = head.target;
                    btb_valid_o  = 1'b1;
                    btb_ctr_o    = ctr_next(btb_ctr_rd_i, head.taken);
                end
            end
            ST_INVAL: begin
                btb_we_o  = 1'b1;
                btb_idx_o = sweep_q;
            end
            default: ;
        endcase
    end

    assign inv_busy_o = (state_q == ST_INVAL);

    // Mispredict is judged at acceptance, independent of buffer/sweep state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q   <= 1'b0;
            redir_q <= '0;
        end else begin
            mis_q <= push && (res_taken_i != res_pred_taken_i);
            if (push && (res_taken_i != res_pred_taken_i))
                redir_q <= res_taken_i ? res_target_i : res_pc_i + 32'd4;
        end
    end

    assign mispredict_o  = mis_q;
    assign redirect_pc_o = redir_q;

`ifdef BTB_UPD_STATS_EN
    logic [15:0] upd_cnt_q, mis_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (pop && upd_cnt_q != 16'hFFFF)   upd_cnt_q <= upd_cnt_q + 16'd1;
            if (mis_q && mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    assign stat_upd_o = upd_cnt_q;
    assign stat_mis_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed bench for btb_update_ctrl with an abstract
// reference model (queue of pending resolutions + sweep countdown) checked
// every cycle, plus literal expectations for the key scenarios.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        res_valid = 1'b0, res_taken = 1'b0, res_pred = 1'b0, inv_req = 1'b0;
    logic [31:0] res_pc = '0, res_target = '0;
    logic [1:0]  ctr_rd = '0;
    logic        res_ready_o, inv_busy_o, btb_we_o, btb_valid_o, mispredict_o;
    logic [7:0]  btb_idx_o;
    logic [3:0]  btb_tag_o;
    logic [31:0] btb_target_o, redirect_pc_o;
    logic [1:0]  btb_ctr_o;

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .res_valid_i(res_valid), .res_pc_i(res_pc), .res_target_i(res_target),
        .res_taken_i(res_taken), .res_pred_taken_i(res_pred), .res_ready_o(res_ready_o),
        .inv_req_i(inv_req), .inv_busy_o(inv_busy_o),
        .btb_we_o(btb_we_o), .btb_idx_o(btb_idx_o), .btb_tag_o(btb_tag_o),
        .btb_target_o(btb_target_o), .btb_valid_o(btb_valid_o), .btb_ctr_o(btb_ctr_o),
        .btb_ctr_rd_i(ctr_rd), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o)
    );

    int nvec = 0, nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] tgt; logic tk; } ent_t;
    ent_t        q[$];
    int          sweep_left = 0;   // remaining invalidation writes
    bit          drain = 0;        // writing queued entries out
    logic        m_mis = 1'b0;
    logic [31:0] m_redir = '0;
    int          m_pre;
    bit          m_acc, m_wr;
    ent_t        m_e;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); sweep_left = 0; drain = 0; m_mis = 1'b0; m_redir = '0;
        end else begin
            m_pre = q.size();
            m_acc = res_valid && (m_pre < 4);
            m_wr  = (sweep_left == 0) && drain && (m_pre > 0);
            if (m_acc) begin
                m_mis = (res_taken != res_pred);
                if (m_mis) m_redir = res_taken ? res_target : res_pc + 32'd4;
            end else m_mis = 1'b0;
            if (m_wr) void'(q.pop_front());
            if (m_acc) begin
                m_e.pc = res_pc; m_e.tgt = res_target; m_e.tk = res_taken;
                q.push_back(m_e);
            end
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0) drain = (m_pre > 0);
            end else if (inv_req) begin
                sweep_left = 256; drain = 0;
            end else if (drain) drain = (q.size() > 0);
            else drain = (m_pre > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        e_we, e_valid;
    logic [7:0]  e_idx;
    logic [3:0]  e_tag;
    logic [31:0] e_tgt;
    int          e_ctr;

    initial forever begin
        @(negedge clk);
        e_we = 0; e_valid = 0; e_idx = 0; e_tag = 0; e_tgt = 0; e_ctr = 0;
        if (sweep_left > 0) begin
            e_we = 1; e_idx = 8'(256 - sweep_left);
        end else if (drain && q.size() > 0) begin
            e_we = 1; e_valid = 1;
            e_idx = q[0].pc[9:2]; e_tag = q[0].pc[13:10]; e_tgt = q[0].tgt;
            e_ctr = q[0].tk ? ((int'(ctr_rd) + 1 > 3) ? 3 : int'(ctr_rd) + 1)
                            : ((int'(ctr_rd) == 0) ? 0 : int'(ctr_rd) - 1);
        end
        chk("ready",    res_ready_o,   q.size() < 4);
        chk("busy",     inv_busy_o,    sweep_left > 0);
        chk("we",       btb_we_o,      e_we);
        chk("idx",      btb_idx_o,     e_idx);
        chk("tag",      btb_tag_o,     e_tag);
        chk("target",   btb_target_o,  e_tgt);
        chk("valid",    btb_valid_o,   e_valid);
        chk("ctr",      btb_ctr_o,     e_ctr);
        chk("mis",      mispredict_o,  m_mis);
        chk("redirect", redirect_pc_o, m_redir);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] tg,
                        input logic tk, input logic pr, output int waited);
        res_valid = 1; res_pc = pc; res_target = tg; res_taken = tk; res_pred = pr;
        waited = 0;
        while (!res_ready_o && waited < 400) begin cyc(); waited++; end
        if (!res_ready_o) chk("send_timeout", 0, 1);
        cyc();
        res_valid = 0;
    endtask

    task automatic pulse_inv();
        inv_req = 1; cyc(); inv_req = 0;
    endtask

    int w, busy_cnt, seq_ok, wr_cnt;

    initial begin
        #1 rst_n = 0;
        repeat (3) cyc();
        chk("rst_ready", res_ready_o, 1);
        chk("rst_we", btb_we_o, 0);
        chk("rst_busy", inv_busy_o, 0);
        rst_n = 1;
        cyc();

        // single resolution, correctly predicted taken
        ctr_rd = 2'd1;
        send(32'h0000_1234, 32'h0000_2000, 1, 1, w);
        chk("t1_mis", mispredict_o, 0);
        cyc();
        chk("t1_we", btb_we_o, 1);
        chk("t1_idx", btb_idx_o, 8'h8D);
        chk("t1_tag", btb_tag_o, 4'h4);
        chk("t1_tgt", btb_target_o, 32'h2000);
        chk("t1_valid", btb_valid_o, 1);
        chk("t1_ctr", btb_ctr_o, 2);
        repeat (2) cyc();

        // counter saturation both ways
        ctr_rd = 2'd3;
        send(32'h0000_0040, 32'h0000_0080, 1, 1, w);
        cyc();
        chk("sat_hi", btb_ctr_o, 3);
        repeat (2) cyc();
        ctr_rd = 2'd0;
        send(32'h0000_0044, 32'h0000_0090, 0, 0, w);
        cyc();
        chk("sat_lo", btb_ctr_o, 0);
        chk("sat_lo_v", btb_valid_o, 1);
        repeat (2) cyc();

        // mispredicts: not-taken wraps pc+4, then taken redirects to target
        send(32'hFFFF_FFFC, 32'h0000_0100, 0, 1, w);
        chk("mis_nt", mispredict_o, 1);
        chk("mis_nt_pc", redirect_pc_o, 32'h0000_0000);
        send(32'h0000_0500, 32'h0000_1234, 1, 0, w);
        chk("mis_t", mispredict_o, 1);
        chk("mis_t_pc", redirect_pc_o, 32'h0000_1234);
        cyc();
        chk("mis_hold", redirect_pc_o, 32'h0000_1234);
        repeat (4) cyc();

        // back-to-back burst with varying counters, then sweep mid-drain
        for (int i = 0; i < 6; i++) begin
            ctr_rd = 2'(i);
            send(32'h0000_3000 + 32'(i * 4), 32'h0000_8000 + 32'(i), 1'(i % 2), 1'(i % 3 == 0), w);
        end
        ctr_rd = 2'd2;
        for (int i = 0; i < 3; i++) send(32'h0000_4000 + 32'(i * 8), 32'h0000_9000, 1, 1, w);
        pulse_inv();
        w = 0;
        while (inv_busy_o && w < 400) begin cyc(); w++; end
        chk("inval_mid_done", inv_busy_o, 0);
        repeat (6) cyc();

        // standalone sweep from IDLE, with an ignored request mid-sweep
        pulse_inv();
        busy_cnt = 0; seq_ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (inv_busy_o) begin
                busy_cnt++;
                if (btb_we_o && !btb_valid_o && btb_idx_o == 8'(seq_ok)) seq_ok++;
            end
            inv_req = (i == 50);
            cyc();
        end
        inv_req = 0;
        chk("sweep_busy_cycles", busy_cnt, 256);
        chk("sweep_idx_seq", seq_ok, 256);

        // five resolutions while the sweep stalls writes
        pulse_inv();
        for (int i = 0; i < 4; i++) send(32'h0000_5000 + 32'(i * 4), 32'h0000_6000, 0, 1, w);
        chk("full_ready", res_ready_o, 0);
        send(32'h0000_5010, 32'h0000_7000, 1, 1, w);
        chk("fifth_wait", w, 253);
        repeat (10) cyc();

        // reset in the middle of a sweep
        pulse_inv();
        repeat (100) cyc();
        chk("rst_at_idx", btb_idx_o, 100);
        #2 rst_n = 0;
        #1;
        chk("arst_we", btb_we_o, 0);
        chk("arst_idx", btb_idx_o, 0);
        chk("arst_busy", inv_busy_o, 0);
        chk("arst_ready", res_ready_o, 1);
        chk("arst_mis", mispredict_o, 0);
        chk("arst_redir", redirect_pc_o, 0);
        repeat (2) cyc();
        rst_n = 1;
        wr_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (btb_we_o) wr_cnt++;
            cyc();
        end
        chk("no_resume", wr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
